// File: rtl/mux_bist_pkg.sv
// Shared types and constants for the 2:1 mux self-test engine.
// Holds the FSM state encoding, vector bit layout and the golden mux function.
package mux_bist_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NUM_VECTORS = 8;
    localparam int VEC_W       = 3;

    // Layout of the vector index: v = {sel, a, b}
    localparam int SEL_BIT = 2;
    localparam int A_BIT   = 1;
    localparam int B_BIT   = 0;

    function automatic logic mux_ref(input logic sel, input logic a, input logic b);
        return sel ? b : a;
    endfunction

endpackage

// File: rtl/mux_bist_golden.sv
// Combinational reference model: expected mux output Z for vector index v.
// Kept separate so AND/OR/XOR-via-mux golden models can be dropped in later.
module mux_bist_golden
    import mux_bist_pkg::*;
(
    input  logic [VEC_W-1:0] vec,
    output logic             expected
);

    assign expected = mux_ref(vec[SEL_BIT], vec[A_BIT], vec[B_BIT]);

endmodule

// File: rtl/mux_bist_seq.sv
// Sequential stimulus/check engine for the 2:1 mux cell: walks all 8 (sel,a,b)
// vectors, samples z_in after SETTLE_CYCLES and counts mismatches. Optional macro: MUX_BIST_FIRST_FAIL_EN.
module mux_bist_seq
    import mux_bist_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int ERR_W         = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             z_in,
    output logic             a_out,
    output logic             b_out,
    output logic             sel_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
`ifdef MUX_BIST_FIRST_FAIL_EN
    output logic             first_fail_vld,
    output logic [VEC_W-1:0] first_fail_vec,
`endif
    output logic [ERR_W-1:0] err_cnt
);

    localparam int                HOLD_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(SETTLE_CYCLES - 1);
    localparam logic [VEC_W-1:0]  VEC_LAST  = VEC_W'(NUM_VECTORS - 1);
    localparam logic [ERR_W-1:0]  ERR_MAX   = '1;

    state_t             state_q, state_d;
    logic [VEC_W-1:0]   vec_q, vec_d;
    logic [VEC_W-1:0]   drive_q, drive_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic               z_exp;
    logic               mismatch;
`ifdef MUX_BIST_FIRST_FAIL_EN
    logic               ff_vld_q, ff_vld_d;
    logic [VEC_W-1:0]   ff_vec_q, ff_vec_d;
`endif

    mux_bist_golden u_golden (
        .vec      (vec_q),
        .expected (z_exp)
    );

    assign mismatch = (z_in != z_exp);

    // NOTE: every signal gets its default first so no path leaves one unassigned and infers a latch.
    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        drive_d  = drive_q;
        hold_d   = hold_q;
        err_d    = err_q;
        busy_d   = busy_q;
        done_d   = done_q;
        pass_d   = pass_q;
`ifdef MUX_BIST_FIRST_FAIL_EN
        ff_vld_d = ff_vld_q;
        ff_vec_d = ff_vec_q;
`endif
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d  = RUN;
                    vec_d    = '0;
                    drive_d  = '0;
                    hold_d   = '0;
                    err_d    = '0;
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
                    pass_d   = 1'b0;
`ifdef MUX_BIST_FIRST_FAIL_EN
                    ff_vld_d = 1'b0;
                    ff_vec_d = '0;
`endif
                end
            end
            RUN: begin
                if (hold_q != HOLD_LAST) begin
                    hold_d = hold_q + 1'b1;
                end else begin
                    hold_d = '0;
                    if (mismatch && (err_q != ERR_MAX)) begin
                        err_d = err_q + 1'b1;
                    end
`ifdef MUX_BIST_FIRST_FAIL_EN
                    if (mismatch && !ff_vld_q) begin
                        ff_vld_d = 1'b1;
                        ff_vec_d = vec_q;
                    end
`endif
                    if (vec_q == VEC_LAST) begin
                        state_d = DONE;
                        drive_d = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_d == '0);
                    end else begin
                        vec_d   = vec_q + 1'b1;
                        drive_d = vec_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            vec_q    <= '0;
            drive_q  <= '0;
            hold_q   <= '0;
            err_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
`ifdef MUX_BIST_FIRST_FAIL_EN
            ff_vld_q <= 1'b0;
            ff_vec_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            vec_q    <= vec_d;
            drive_q  <= drive_d;
            hold_q   <= hold_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
`ifdef MUX_BIST_FIRST_FAIL_EN
            ff_vld_q <= ff_vld_d;
            ff_vec_q <= ff_vec_d;
`endif
        end
    end

    assign sel_out = drive_q[SEL_BIT];
    assign a_out   = drive_q[A_BIT];
    assign b_out   = drive_q[B_BIT];
    assign busy    = busy_q;
    assign done    = done_q;
    assign pass    = pass_q;
    assign err_cnt = err_q;
`ifdef MUX_BIST_FIRST_FAIL_EN
    assign first_fail_vld = ff_vld_q;
    assign first_fail_vec = ff_vec_q;
`endif

endmodule

// File: doc/mux_bist_seq.md
# mux_bist_seq

Sequential stimulus/check engine that sits directly upstream of the 2:1 `mux` cell (ports A, B, Sel → Z) and its mux-built basic gates. On a start pulse it drives all 8 (Sel, A, B) combinations into the mux, samples Z after a programmable settle time, and compares it with the golden function Z = Sel ? B : A. It reports busy/done, a saturating error count and pass/fail, giving the gate library a synthesizable self-test in place of a simulation-only bench.

## Interface
- SETTLE_CYCLES, 1: clock cycles each vector is held; Z is sampled on the last edge of the hold (≥1).
- ERR_W, 4: width of the error counter.

- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to run a test pass.
- z_in  in  1  mux output Z fed back from the DUT.
- a_out  out  1  drives mux A.
- b_out  out  1  drives mux B.
- sel_out  out  1  drives mux Sel.
- busy  out  1  high while vectors are being applied.
- done  out  1  high from pass completion until the next accepted start or reset.
- pass  out  1  valid while done: 1 when err_cnt == 0.
- err_cnt  out  ERR_W  mismatches in the current/last pass, saturating.
- first_fail_vld / first_fail_vec  out  1 / 3  present only with MUX_BIST_FIRST_FAIL_EN.

## Operation
- States: IDLE → RUN → DONE. A start in DONE → RUN. Reset → IDLE.
- Vector index v = 0..7 maps to sel_out = v[2], a_out = v[1], b_out = v[0]. Expected Z = sel_out ? b_out : a_out.
- IDLE: outputs are 0. done = 0. busy = 0.
- start in IDLE or DONE:
  - Clears err_cnt and the first-fail record.
  - Sets v = 0 and the hold counter to 0.
  - Enters RUN and drives vector 0.
- RUN: each vector is held SETTLE_CYCLES edges. On the last edge, compare z_in with the expected value:
  - On a mismatch, err_cnt increments and saturates at 2^ERR_W − 1.
  - Then advance v.
  - After vector 7 is sampled: enter DONE, drop busy, raise done, return a/b/sel outputs to 0.
- start while in RUN is ignored.
- DONE holds err_cnt, pass and the first-fail record stable.
- All outputs are registered. z_in is sampled only on the compare edge.

## Timing
- Reset values: a_out = b_out = sel_out = 0, busy = 0, done = 0, pass = 0, err_cnt = 0, first_fail_vld = 0, first_fail_vec = 0.
- Start sampled at edge t0. Vector 0 is visible after t0, and busy = 1 from t0.
- Vector k is sampled at edge t0 + (k+1)·SETTLE_CYCLES.
- done = 1 after edge t0 + 8·SETTLE_CYCLES. Busy is 8·SETTLE_CYCLES cycles long.
- The mux is combinational, so z_in must settle within one cycle of a vector change. SETTLE_CYCLES > 1 covers gate chains.
- rst mid-RUN: back to IDLE on that edge with reset values. The partial count is discarded.
- start and rst in the same cycle: rst wins.

## Configuration
- Macro: MUX_BIST_FIRST_FAIL_EN.
- Defined: first_fail_vld and first_fail_vec exist. On the first mismatch of a pass, both are latched (vld = 1, vec = v). Later mismatches do not overwrite them. Both are cleared on an accepted start or reset.
- Undefined: both ports and their registers are absent. All other behaviour is identical.

## Structure
- Shared package `mux_bist_pkg` holds:
  - state enum (IDLE, RUN, DONE)
  - NUM_VECTORS = 8
  - vector bit positions (SEL_BIT = 2, A_BIT = 1, B_BIT = 0)
  - golden function `mux_ref(sel, a, b)`
- One sub-module, `mux_bist_golden`: combinational reference model returning the expected Z for v. It can later be swapped for AND/OR/XOR-via-mux golden models.
- The FSM, hold counter, vector counter and error counter stay in mux_bist_seq.

## Test plan
- Good mux, SETTLE_CYCLES = 1, start pulse → busy for 8 cycles, sel/a/b walk 000…111, done = 1, err_cnt = 0, pass = 1.
- z_in tied 0 → err_cnt = 4 (v = 2, 3, 5, 7), pass = 0. With the macro: first_fail_vec = 2.
- Inverted mux, ERR_W = 2 → err_cnt saturates at 3, pass = 0. With the macro: first_fail_vec = 0.
- SETTLE_CYCLES = 3 → each vector held 3 cycles, done 24 cycles after the start edge, result matches the good case.
- start re-pulsed at cycle 4 of RUN → ignored, done still at cycle 8. Then start in DONE → err_cnt cleared, new pass runs.
- rst asserted at cycle 5 of RUN → next cycle all outputs 0 in IDLE. A later start runs a full clean pass.
